baud_rate_gen_frac: RTL and testbench

//  Runtime-programmable UART baud generator with fractional divisor and oversampling.

---
 rtl/baud_rate_gen_frac.sv | 118 +++++++++++
 tb/tb_baud_rate_gen_frac.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/baud_rate_gen_frac.sv
// Fractional-divisor UART baud generator with oversample and bit ticks.
// Divisor reloads are deferred to bit boundaries, restart or idle.
module baud_rate_gen_frac #(
  parameter int CNT_W        = 16,
  parameter int FRAC_W       = 4,
  parameter int OVS          = 16,
  parameter int RST_DIV_INT  = 651,
  parameter int RST_DIV_FRAC = 1,
  localparam int PH_W        = $clog2(OVS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              restart,
  input  logic [CNT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  output logic              div_ack,
  output logic              os_tick,
  output logic              baud_tick,
  output logic [PH_W-1:0]   os_phase
);

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVS - 1);
  localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(2);

  logic [CNT_W-1:0]  cnt_q;
  logic [FRAC_W-1:0] acc_q;
  logic              ext_q;
  logic [PH_W-1:0]   ph_q;

  logic [CNT_W-1:0]  d_int_q;
  logic [FRAC_W-1:0] d_frac_q;
  logic              pend_q;
  logic [CNT_W-1:0]  p_int_q;
  logic [FRAC_W-1:0] p_frac_q;
  logic              ack_q;

  logic [CNT_W:0]    lim;
  logic              term;
  logic              tick;
  logic              btick;
  logic              apply;
  logic [CNT_W-1:0]  ld_int;
  logic [FRAC_W:0]   sum;

  // Terminal count, tick decode and reload qualification
  always_comb begin
    lim = {1'b0, d_int_q}
        - {{CNT_W{1'b0}}, 1'b1}
        + {{CNT_W{1'b0}}, ext_q};
    term = ({1'b0, cnt_q} == lim);
    tick = reset & en & ~restart & term;
    btick = tick & (ph_q == PH_LAST);
    ld_int = (div_int < DIV_MIN) ? DIV_MIN : div_int;
    apply = (pend_q | div_load)
          & (btick | restart | ~en);
    sum = {1'b0, acc_q} + {1'b0, d_frac_q};
  end

  assign os_tick   = tick;
  assign baud_tick = btick;
  assign div_ack   = reset & ack_q;
  assign os_phase  = reset ? ph_q : '0;

  // Prescaler counter with fractional carry accumulator
  always_ff @(posedge clk) begin
    if (!reset || restart) begin
      cnt_q <= '0;
      acc_q <= '0;
      ext_q <= 1'b0;
    end else if (tick) begin
      cnt_q <= '0;
      acc_q <= sum[FRAC_W-1:0];
      ext_q <= sum[FRAC_W];
    end else if (en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Oversample phase index, wraps every OVS ticks
  always_ff @(posedge clk) begin
    if (!reset || restart) begin
      ph_q <= '0;
    end else if (tick) begin
      ph_q <= (ph_q == PH_LAST) ? '0 : ph_q + PH_W'(1);
    end
  end

  // Pending and active divisor registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      d_int_q  <= CNT_W'(RST_DIV_INT);
      d_frac_q <= FRAC_W'(RST_DIV_FRAC);
      pend_q   <= 1'b0;
      p_int_q  <= '0;
      p_frac_q <= '0;
    end else if (apply) begin
      d_int_q  <= div_load ? ld_int : p_int_q;
      d_frac_q <= div_load ? div_frac : p_frac_q;
      pend_q   <= 1'b0;
    end else if (div_load) begin
      pend_q   <= 1'b1;
      p_int_q  <= ld_int;
      p_frac_q <= div_frac;
    end
  end

  // One-cycle acknowledge after a divisor becomes active
  always_ff @(posedge clk) begin
    if (!reset) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= apply;
    end
  end

endmodule

// File: tb/tb_baud_rate_gen_frac.sv
// Directed bench for baud_rate_gen_frac (FRAC_W=4, OVS=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_baud_rate_gen_frac;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        restart;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        div_load;
  logic        div_ack;
  logic        os_tick;
  logic        baud_tick;
  logic [1:0]  os_phase;

  int checks = 0;
  int failures = 0;

  baud_rate_gen_frac #(
    .CNT_W(16), .FRAC_W(4), .OVS(4),
    .RST_DIV_INT(651), .RST_DIV_FRAC(1)
  ) dut (
    .clk(clk), .reset(reset), .en(en),
    .restart(restart), .div_int(div_int),
    .div_frac(div_frac), .div_load(div_load),
    .div_ack(div_ack), .os_tick(os_tick),
    .baud_tick(baud_tick), .os_phase(os_phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic wait_os(output int n);
    bit done;
    n = 0;
    done = 0;
    while (!done) begin
      @(negedge clk);
      n++;
      if (os_tick === 1'b1) done = 1;
      else if (n >= 2000) begin
        chk("os_tick_timeout", 32'(n), 32'(0));
        done = 1;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  int n;
  int tot;
  int tk;

  initial begin
    reset = 0; en = 0; restart = 0;
    div_int = 0; div_frac = 0; div_load = 0;
    step(); step();
    chk("rst_os_tick", 32'(os_tick), 0);
    chk("rst_baud", 32'(baud_tick), 0);
    chk("rst_ack", 32'(div_ack), 0);
    chk("rst_phase", 32'(os_phase), 0);

    // 1: load 4/0 while idle, then run
    reset = 1; div_load = 1;
    div_int = 4; div_frac = 0;
    step();
    chk("t1_ack", 32'(div_ack), 1);
    div_load = 0; en = 1;
    wait_os(n);
    chk("t1_first", 32'(n), 3);
    chk("t1_ph0", 32'(os_phase), 0);
    for (int i = 1; i < 4; i++) begin
      wait_os(n);
      chk("t1_period", 32'(n), 4);
      chk("t1_phase", 32'(os_phase), 32'(i));
    end
    chk("t1_baud", 32'(baud_tick), 1);
    tot = 0;
    for (int i = 0; i < 4; i++) begin
      wait_os(n);
      tot += n;
    end
    chk("t1_bit_len", 32'(tot), 16);
    chk("t1_baud2", 32'(baud_tick), 1);

    // 2: restart on terminal count, load 4/8
    chk("t2_pre_tick", 32'(os_tick), 1);
    restart = 1; div_load = 1;
    div_int = 4; div_frac = 8;
    #1;
    chk("t2_rst_wins", 32'(os_tick), 0);
    step();
    chk("t2_ack", 32'(div_ack), 1);
    chk("t2_phase", 32'(os_phase), 0);
    restart = 0; div_load = 0;
    wait_os(n);
    chk("t2_first", 32'(n), 3);
    tot = 0;
    wait_os(n);
    chk("t2_p4", 32'(n), 4);
    tot += n;
    wait_os(n);
    chk("t2_p5", 32'(n), 5);
    tot += n;
    for (int i = 0; i < 30; i++) begin
      wait_os(n);
      tot += n;
    end
    chk("t2_32_ticks", 32'(tot), 144);

    // 3: deferred reload 6/0 issued at phase 1
    restart = 1; div_load = 1;
    div_int = 4; div_frac = 0;
    step();
    chk("t3_ack0", 32'(div_ack), 1);
    restart = 0; div_load = 0;
    wait_os(n);
    chk("t3_first", 32'(n), 3);
    step();
    chk("t3_ph1", 32'(os_phase), 1);
    div_load = 1; div_int = 6;
    step();
    div_load = 0;
    chk("t3_no_ack", 32'(div_ack), 0);
    wait_os(n);
    chk("t3_rem", 32'(n), 2);
    wait_os(n);
    chk("t3_p2", 32'(n), 4);
    wait_os(n);
    chk("t3_p3", 32'(n), 4);
    chk("t3_baud", 32'(baud_tick), 1);
    chk("t3_ack_late", 32'(div_ack), 0);
    step();
    chk("t3_ack", 32'(div_ack), 1);
    wait_os(n);
    chk("t3_new_first", 32'(n), 5);
    wait_os(n);
    chk("t3_new_p", 32'(n), 6);

    // 4: restart coincident with terminal count
    for (int i = 0; i < 5; i++) step();
    step();
    chk("t4_pre_tick", 32'(os_tick), 1);
    restart = 1;
    #1;
    chk("t4_no_tick", 32'(os_tick), 0);
    chk("t4_no_baud", 32'(baud_tick), 0);
    step();
    restart = 0;
    chk("t4_phase", 32'(os_phase), 0);
    chk("t4_no_ack", 32'(div_ack), 0);
    wait_os(n);
    chk("t4_realign", 32'(n), 5);
    chk("t4_ph_tick", 32'(os_phase), 0);

    // 5: freeze for 10 clocks mid-period
    step(); step();
    en = 0;
    tk = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (os_tick || baud_tick) tk++;
    end
    chk("t5_ticks", 32'(tk), 0);
    chk("t5_phase", 32'(os_phase), 1);
    en = 1;
    wait_os(n);
    chk("t5_remain", 32'(n), 4);
    chk("t5_ph_tick", 32'(os_phase), 1);

    // 6: reset with a pending load discards it
    div_load = 1; div_int = 10;
    step();
    div_load = 0;
    chk("t6_pend", 32'(div_ack), 0);
    step();
    reset = 0;
    #1;
    chk("t6_os", 32'(os_tick), 0);
    chk("t6_baud", 32'(baud_tick), 0);
    chk("t6_ack", 32'(div_ack), 0);
    chk("t6_phase", 32'(os_phase), 0);
    step();
    reset = 1;
    wait_os(n);
    chk("t6_def_first", 32'(n), 650);
    chk("t6_ph", 32'(os_phase), 0);
    wait_os(n);
    chk("t6_def_p", 32'(n), 651);
    restart = 1;
    step();
    restart = 0;
    chk("t6_discard", 32'(div_ack), 0);
    wait_os(n);
    chk("t6_after_rst", 32'(n), 650);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
